// File: rtl/aps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aps_pkg
//  Description : Shared constants and state encoding for the serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package aps_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

endpackage : aps_pkg
`default_nettype wire

// File: rtl/fulladder4.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder4
//  Description : Combinational 4-bit adder with carry in/out.
//  Revision    : 1.0 - initial release
// ============================================================================
module fulladder4
    import aps_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                carry_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                carry_o
);

    logic [NIBBLE_W:0] w_total;

    assign w_total = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, carry_i};
    assign sum_o   = w_total[NIBBLE_W-1:0];
    assign carry_o = w_total[NIBBLE_W];

endmodule : fulladder4
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : WIDTH-bit adder that reuses one fulladder4, one nibble per
//                cycle, with valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import aps_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    serial_state_t       r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                r_ovf;
    logic                r_ready;
    logic                r_valid;

    logic [CNT_W+1:0]    w_slot;
    logic [NIBBLE_W-1:0] w_fa_sum;
    logic                w_fa_carry;

    // Bit offset of the nibble handled this cycle.
    assign w_slot = {r_cnt, 2'b00};

    fulladder4 u_fa (
        .a_i     (r_a[w_slot +: NIBBLE_W]),
        .b_i     (r_b[w_slot +: NIBBLE_W]),
        .carry_i (r_carry),
        .sum_o   (w_fa_sum),
        .carry_o (w_fa_carry)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i && r_ready) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_carry <= carry_i;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[w_slot +: NIBBLE_W] <= w_fa_sum;
                    r_carry                   <= w_fa_carry;
                    if (r_cnt == C_LAST) begin
                        // The top nibble of the sum is on w_fa_sum this cycle.
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_fa_sum[NIBBLE_W-1] != r_a[WIDTH-1]);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign valid_o    = r_valid;
    assign sum_o      = r_sum;
    assign carry_o    = r_carry;
    assign overflow_o = r_ovf;

endmodule : nibble_serial_adder
`default_nettype wire
